// File: rtl/imul_iter_rtl.sv
// Iterative shift-add multiplier: low p_nbits bits of req_a * req_b over p_nbits cycles,
// with val/rdy handshakes on the request and response sides.
module imul_iter_rtl #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_result
);

    localparam int CW = (p_nbits > 1) ? $clog2(p_nbits) : 1;
    localparam logic [CW-1:0] LAST = CW'(p_nbits - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [p_nbits-1:0] a_reg;
    logic [p_nbits-1:0] b_reg;
    logic [p_nbits-1:0] acc;
    logic [CW-1:0]      count;

    // Product is taken modulo 2^p_nbits, so the carry out of the add is dropped.
    function automatic logic [p_nbits-1:0] add_wrap(input logic [p_nbits-1:0] x,
                                                    input logic [p_nbits-1:0] y);
        return x + y;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_val) state_next = CALC;
            CALC:    if (count == LAST) state_next = DONE;
            DONE:    if (resp_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val) begin
                        a_reg <= req_a;
                        b_reg <= req_b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                CALC: begin
                    if (b_reg[0]) acc <= add_wrap(acc, a_reg);
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state only; acc is held stable in DONE.
    assign req_rdy     = (state == IDLE);
    assign resp_val    = (state == DONE);
    assign resp_result = acc;

endmodule

// File: tb/tb_imul_iter_rtl.sv
// Bench for imul_iter_rtl: directed vector table, handshake corner cases, and a
// scoreboard-checked random stream; a second 8-bit instance covers the narrow width.
module tb_imul_iter_rtl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_val;
    logic        resp_rdy = 1'b0;
    logic [31:0] resp_result;

    logic        r8_req_val = 1'b0;
    logic        r8_req_rdy;
    logic [7:0]  r8_req_a = '0;
    logic [7:0]  r8_req_b = '0;
    logic        r8_resp_val;
    logic        r8_resp_rdy = 1'b1;
    logic [7:0]  r8_resp_result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    imul_iter_rtl #(.p_nbits(32)) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_result(resp_result)
    );

    imul_iter_rtl #(.p_nbits(8)) dut8 (
        .clk(clk), .rst(rst),
        .req_val(r8_req_val), .req_rdy(r8_req_rdy), .req_a(r8_req_a), .req_b(r8_req_b),
        .resp_val(r8_resp_val), .resp_rdy(r8_resp_rdy), .resp_result(r8_resp_result)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        logic [63:0] p;
        if (!rst) begin
            if (req_val && req_rdy) begin
                p = 64'(req_a) * 64'(req_b);
                sb.push_back(p[31:0]);
            end
            if (resp_val && resp_rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected response", resp_result, 32'hxxxx_xxxx);
                end else begin
                    check("scoreboard result", resp_result, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        req_a = a;
        req_b = b;
        req_val = 1'b1;
        while (!req_rdy && n < 400) begin
            tick();
            n++;
        end
        tick();
        req_val = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!resp_val && cyc < 200) begin
            tick();
            cyc++;
        end
        check("resp_val arrives", 32'(resp_val), 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cyc;
        int n;
        bit done;
        bit rdy_seen;

        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[1] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0000};
        vecs[2] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        vecs[3] = '{32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF};
        vecs[4] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
        vecs[6] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        vecs[7] = '{32'h0000_1234, 32'h0000_0100, 32'h0012_3400};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset req_rdy", 32'(req_rdy), 32'd1);
        check("reset resp_val", 32'(resp_val), 32'd0);
        check("reset resp_result", resp_result, 32'd0);

        // Basic 3 x 5 with latency
        resp_rdy = 1'b1;
        issue(32'd3, 32'd5);
        check("req_rdy drops after accept", 32'(req_rdy), 32'd0);
        wait_resp(cyc);
        check("latency 3x5", 32'(cyc), 32'd32);
        check("result 3x5", resp_result, 32'd15);
        tick();
        check("req_rdy after handshake", 32'(req_rdy), 32'd1);
        check("resp_val after handshake", 32'(resp_val), 32'd0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_resp(cyc);
            check($sformatf("vec%0d latency", i), 32'(cyc), 32'd32);
            check($sformatf("vec%0d result", i), resp_result, vecs[i].exp);
            tick();
        end

        // Backpressure 7 x 6
        resp_rdy = 1'b0;
        issue(32'd7, 32'd6);
        wait_resp(cyc);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp resp_val c%0d", i), 32'(resp_val), 32'd1);
            check($sformatf("bp result c%0d", i), resp_result, 32'd42);
            tick();
        end
        resp_rdy = 1'b1;
        tick();
        check("bp req_rdy after release", 32'(req_rdy), 32'd1);
        check("bp resp_val after release", 32'(resp_val), 32'd0);

        // Junk requests during CALC and DONE must be ignored
        resp_rdy = 1'b0;
        issue(32'd11, 32'd13);
        rdy_seen = 1'b0;
        n = 0;
        while (!resp_val && n < 200) begin
            req_val = ~req_val;
            req_a = $urandom;
            req_b = $urandom;
            tick();
            n++;
            if (req_rdy) rdy_seen = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            req_val = ~req_val;
            req_a = $urandom;
            req_b = $urandom;
            tick();
            if (req_rdy) rdy_seen = 1'b1;
        end
        req_val = 1'b0;
        check("junk req_rdy stays low", 32'(rdy_seen), 32'd0);
        check("junk resp_val held", 32'(resp_val), 32'd1);
        check("junk result", resp_result, 32'd143);
        resp_rdy = 1'b1;
        tick();
        check("junk req_rdy after handshake", 32'(req_rdy), 32'd1);
        check("junk no extra response", 32'(resp_val), 32'd0);
        check("junk scoreboard empty", 32'(sb.size()), 32'd0);

        // Reset at cycle 10 of CALC
        issue(32'd100, 32'd200);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("midrst req_rdy", 32'(req_rdy), 32'd1);
        check("midrst resp_val", 32'(resp_val), 32'd0);
        check("midrst resp_result", resp_result, 32'd0);
        issue(32'd9, 32'd9);
        wait_resp(cyc);
        check("midrst 9x9 latency", 32'(cyc), 32'd32);
        check("midrst 9x9 result", resp_result, 32'd81);
        tick();

        // Reset and request together: reset wins
        req_a = 32'd5;
        req_b = 32'd5;
        req_val = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_val = 1'b0;
        check("rst+req req_rdy", 32'(req_rdy), 32'd1);

        // Random back-to-back stream with stalls
        for (int k = 0; k < 200; k++) begin
            issue($urandom, (k % 17 == 0) ? 32'hFFFF_FFFF : $urandom);
            done = 1'b0;
            n = 0;
            while (!done && n < 400) begin
                resp_rdy = ($urandom_range(0, 3) != 0);
                done = resp_val && resp_rdy;
                tick();
                n++;
            end
            if (!done) check("rand handshake timeout", 32'(done), 32'd1);
        end
        resp_rdy = 1'b1;
        check("rand scoreboard drained", 32'(sb.size()), 32'd0);

        // 8-bit instance
        r8_req_a = 8'hFF;
        r8_req_b = 8'hFF;
        r8_req_val = 1'b1;
        tick();
        r8_req_val = 1'b0;
        check("w8 req_rdy drops", 32'(r8_req_rdy), 32'd0);
        cyc = 0;
        while (!r8_resp_val && cyc < 50) begin
            tick();
            cyc++;
        end
        check("w8 latency", 32'(cyc), 32'd8);
        check("w8 result", 32'(r8_resp_result), 32'h01);
        tick();
        check("w8 req_rdy after handshake", 32'(r8_req_rdy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
